arb_memory: RTL
===============

Name: arb_memory

Overview:
Parametrised shared scratch memory with NPORTS independent request ports, a configurable wait-state latency and fixed-priority or round-robin arbitration. It replaces the two-port, zero-wait DMA test memory. Port 0 carries the DMA/copier master and higher ports carry test/bench masters. It lets the copier be exercised against realistic memory stalls and contention.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must be <= 2**ADDR_W
NPORTS, 2, number of request ports (1..8)
WAIT_CYCLES, 0, extra cycles between grant and completion (0..15)
ARB_RR, 0, 0 = fixed priority with lowest index highest; 1 = round-robin
RESET_FILL, 0, value written to every word on reset
IDLE_RDATA, 8'hFF, rdata value when a port is not completing a read

Ports:
CLK  in  1  clock; one clock domain, all state on rising edge
RST  in  1  reset; synchronous and active-high
ren  in  NPORTS  per-port read request
wen  in  NPORTS  per-port write request
addr  in  NPORTS*ADDR_W  per-port address; port p occupies slice [p*ADDR_W +: ADDR_W]
wdata  in  NPORTS*DATA_W  per-port write data
rdata  out  NPORTS*DATA_W  per-port read data
ready  out  NPORTS  per-port completion strobe; 1 cycle per serviced request
err  out  NPORTS  per-port out-of-range strobe, coincident with ready
busy  out  1  high while a granted access is waiting

Behaviour:
- Reset (RST=1 at a rising edge):
  - All words are set to RESET_FILL.
  - State goes to IDLE, wait counter to 0, round-robin pointer to 0.
  - Any in-flight access is aborted with no write.
  - While RST=1: ready=0, err=0, busy=0, rdata=IDLE_RDATA on all ports.
- Request: a port requests while ren|wen is high. The master holds addr, wdata, ren and wen stable until it samples ready=1.
- Write vs read: if wen and ren are both high, the access is a write. rdata then shows the pre-write word.
- Arbitration (evaluated in IDLE only):
  - ARB_RR=0: the lowest-index requesting port wins.
  - ARB_RR=1: the search starts at the pointer and wraps modulo NPORTS. After a completion the pointer becomes owner+1, wrapping to 0.
- State machine: IDLE, WAIT.
  - IDLE with no request: stays IDLE.
  - IDLE, request, WAIT_CYCLES=0: the winner completes in the same cycle. ready[w]=1 combinationally, the write commits at the next edge, state stays IDLE. Behaviour matches the old zero-wait memory.
  - IDLE, request, WAIT_CYCLES>0: latch owner=w, counter=WAIT_CYCLES-1, go to WAIT. busy=1 throughout WAIT.
  - WAIT, counter>0: decrement the counter.
  - WAIT, counter=0: ready[owner]=1 for one cycle, the write commits at the edge, return to IDLE.
  - Latency: a request first seen in IDLE at cycle N completes at cycle N+WAIT_CYCLES.
  - Back-to-back requests from one port have an inter-completion spacing of WAIT_CYCLES+1 cycles.
- Owner withdraws (ren=0 and wen=0) during WAIT: the access aborts at that edge. No write, no ready, state returns to IDLE, round-robin pointer unchanged.
- Outputs for non-owners: ready=0 and rdata=IDLE_RDATA. Losing ports keep requesting; there is no queueing.
- rdata[p] equals mem[addr[p]] only when ready[p]=1 and ren[p]=1. Otherwise it equals IDLE_RDATA.
- Out-of-range (addr >= DEPTH) on completion:
  - ready=1 and err=1.
  - A write is dropped.
  - A read returns IDLE_RDATA.
- No other simultaneous write can occur, because only one access completes per cycle.

Test Plan:
- WAIT_CYCLES=0, NPORTS=2: port0 writes 0xA5 to addr 0x10, then reads it back -> ready=1 in the same cycle as each request; the read returns 0xA5; ready[1]=0 throughout.
- WAIT_CYCLES=3: port1 reads addr 0x20 holding 0x3C, request first seen at cycle N -> busy=1 for cycles N..N+2; ready[1]=1 and rdata=0x3C only at cycle N+3.
- ARB_RR=0: ports 0 and 1 both request continuously -> port0 is always served and port1 starves. ARB_RR=1, WAIT_CYCLES=1 -> completions alternate 0,1,0,1 every 2 cycles.
- WAIT_CYCLES=4, port0 write 0x77 to addr 0x05, with ren and wen dropped after 2 cycles -> no ready; mem[0x05] stays 0x00; next request is granted from IDLE.
- DEPTH=200: write 0x11 to addr 0xF0, then read it -> ready=1 and err=1 on both; the read returns 0xFF; no word changes.
- RST asserted during WAIT of a write, held 1 cycle -> no write; all words read RESET_FILL; ready=0 and busy=0 during and after reset until a new request arrives.

Source files
------------

// File: rtl/arb_memory.sv
// Shared scratch memory with NPORTS request ports, WAIT_CYCLES access latency and
// fixed-priority or round-robin arbitration. One access completes per cycle at most.
module arb_memory #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DEPTH       = 256,
  parameter int unsigned       NPORTS      = 2,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter int unsigned       ARB_RR      = 0,
  parameter logic [DATA_W-1:0] RESET_FILL  = '0,
  parameter logic [DATA_W-1:0] IDLE_RDATA  = '1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NPORTS-1:0]        ren,
  input  logic [NPORTS-1:0]        wen,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS*DATA_W-1:0] rdata,
  output logic [NPORTS-1:0]        ready,
  output logic [NPORTS-1:0]        err,
  output logic                     busy
);

  localparam int unsigned PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [NPORTS-1:0]  req;
  logic [PTR_W-1:0]   win;
  logic               win_vld;
  int unsigned        idx;
  logic               done;
  logic [PTR_W-1:0]   done_port;
  logic               busy_c;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic               acc_oor;
  logic [DATA_W-1:0]  rd_word;
  logic               mem_we;

  assign req = ren | wen;

  // Winner search: from index 0 (fixed) or from the round-robin pointer (wrapping)
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      idx = (ARB_RR != 0) ? 32'(ptr_q) + i : i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!win_vld && req[PTR_W'(idx)]) begin
        win_vld = 1'b1;
        win     = PTR_W'(idx);
      end
    end
  end

  // Next-state: grant in IDLE, count down in WAIT, abort if the owner withdraws
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    done      = 1'b0;
    done_port = owner_q;
    busy_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          if (WAIT_CYCLES == 0) begin
            done      = 1'b1;
            done_port = win;
          end else begin
            owner_d = win;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
            busy_c  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!req[owner_q]) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_c = 1'b1;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      ptr_d = (done_port == PTR_W'(NPORTS - 1)) ? '0 : done_port + PTR_W'(1);
    end
  end

  assign acc_addr  = addr[32'(done_port)*ADDR_W +: ADDR_W];
  assign acc_wdata = wdata[32'(done_port)*DATA_W +: DATA_W];
  assign acc_oor   = (32'(acc_addr) >= DEPTH);
  assign rd_word   = acc_oor ? IDLE_RDATA : mem_q[IDX_W'(acc_addr)];
  assign mem_we    = done && wen[done_port] && !acc_oor && !RST;
  assign busy      = busy_c && !RST;

  // Per-port strobes; only the completing port sees memory data
  always_comb begin
    ready = '0;
    err   = '0;
    rdata = {NPORTS{IDLE_RDATA}};
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (!RST && done && (done_port == PTR_W'(p))) begin
        ready[p] = 1'b1;
        err[p]   = acc_oor;
        if (ren[p]) rdata[p*DATA_W +: DATA_W] = rd_word;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) mem_q[d] <= RESET_FILL;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      if (mem_we) mem_q[IDX_W'(acc_addr)] <= acc_wdata;
    end
  end

endmodule
